// File: rtl/axi4_lite_cordic_mc_controller.sv
// AXI4-Lite register front end for a bank of NUM_CH CORDIC cores.
// Each channel exposes THETA/RESULT/CTRL/STATUS; one global IRQ_EN word follows the channel banks.
module axi4_lite_cordic_mc_controller #(
   parameter int          NUM_CH      = 4,
   parameter logic [31:0] BASE_ADDR   = 32'hF000_0100,
   parameter int          CH_STRIDE   = 16,
   parameter int          TIMEOUT_CYC = 1024
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [31:0]           awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [31:0]           araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [32*NUM_CH-1:0]  theta_deg,
   input  logic [32*NUM_CH-1:0]  result_out,
   output logic [NUM_CH-1:0]     mode,
   output logic [NUM_CH-1:0]     start,
   output logic [NUM_CH-1:0]     rst,
   input  logic [NUM_CH-1:0]     done,
   output logic                  irq
);

   localparam int                SH       = $clog2(CH_STRIDE);
   localparam int                CNT_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [31:0]       WIN_SZ   = 32'(NUM_CH * CH_STRIDE);
   localparam logic [31:0]       SUB_MSK  = 32'(CH_STRIDE - 1);
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef struct packed {
      logic       ok;
      logic       glob;
      logic [2:0] ch;
      logic [1:0] rsel;
   } dec_t;

   // Offsets below BASE_ADDR wrap to huge values and fall outside the window.
   function automatic dec_t decode(input logic [31:0] addr);
      dec_t        d;
      logic [31:0] off;
      logic [31:0] idx;
      d   = '0;
      off = addr - BASE_ADDR;
      idx = off >> SH;
      if (addr[1:0] != 2'b00) begin
         d = '0;
      end else if (off == WIN_SZ) begin
         d.ok   = 1'b1;
         d.glob = 1'b1;
      end else if ((off < WIN_SZ) && ((off & SUB_MSK) < 32'd16)) begin
         d.ok   = 1'b1;
         d.ch   = idx[2:0];
         d.rsel = off[3:2];
      end else begin
         d = '0;
      end
      return d;
   endfunction

   logic              aw_held_r, w_held_r, bvalid_r, rvalid_r, irq_r, irq_s;
   logic [31:0]       aw_addr_r, w_data_r, rdata_r, rd_data_s;
   logic [3:0]        w_strb_r;
   logic [1:0]        bresp_r, rresp_r, rd_resp_s;
   logic [31:0]       theta_r [NUM_CH];
   logic [31:0]       theta_s [NUM_CH];
   logic [31:0]       result_r [NUM_CH];
   logic [31:0]       result_s [NUM_CH];
   logic [31:0]       ch_word_s [NUM_CH];
   logic [CNT_W-1:0]  tmo_r [NUM_CH];
   logic [CNT_W-1:0]  tmo_s [NUM_CH];
   logic [NUM_CH-1:0] ctl_rst_r, ctl_rst_s, mode_r, mode_s, done_r, done_s;
   logic [NUM_CH-1:0] busy_r, busy_s, err_r, err_s, start_r, start_s;
   logic [NUM_CH-1:0] irq_en_r, irq_en_s, ch_hit_s;
   logic              commit_s, wr_ok_s, wr_en_s, aw_hs_s, w_hs_s, ar_hs_s;
   dec_t              wdec_s, rdec_s;

   assign aw_hs_s  = awvalid & ~aw_held_r;
   assign w_hs_s   = wvalid & ~w_held_r;
   assign ar_hs_s  = arvalid & ~rvalid_r;
   assign commit_s = aw_held_r & w_held_r & ~bvalid_r;
   assign wdec_s   = decode(aw_addr_r);
   assign rdec_s   = decode(araddr);
   assign wr_ok_s  = wdec_s.ok & ~(~wdec_s.glob & (wdec_s.rsel == 2'b01));
   assign wr_en_s  = commit_s & wr_ok_s;

   // Write-commit decode to a per-channel hit vector.
   always_comb begin
      ch_hit_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_hit_s[i] = wr_en_s & ~wdec_s.glob & (wdec_s.ch == 3'(i));
      end
   end

   // Next-state for all register banks; hardware sets are applied after W1C so they win.
   always_comb begin
      irq_en_s  = irq_en_r;
      ctl_rst_s = ctl_rst_r;
      mode_s    = mode_r;
      done_s    = done_r;
      busy_s    = busy_r;
      err_s     = err_r;
      start_s   = '0;
      if (wr_en_s && wdec_s.glob && w_strb_r[0]) begin
         irq_en_s = w_data_r[NUM_CH-1:0];
      end else begin
         irq_en_s = irq_en_r;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         theta_s[i]  = theta_r[i];
         result_s[i] = result_r[i];
         tmo_s[i]    = busy_r[i] ? tmo_r[i] + CNT_W'(1) : tmo_r[i];
         for (int b = 0; b < 4; b++) begin
            theta_s[i][8*b +: 8] = (ch_hit_s[i] && (wdec_s.rsel == 2'b00) && w_strb_r[b]) ?
                                   w_data_r[8*b +: 8] : theta_r[i][8*b +: 8];
         end
         if (ch_hit_s[i] && (wdec_s.rsel == 2'b10) && w_strb_r[0]) begin
            ctl_rst_s[i] = w_data_r[0];
            mode_s[i]    = w_data_r[2];
         end else begin
            ctl_rst_s[i] = ctl_rst_r[i];
         end
         if (ch_hit_s[i] && (wdec_s.rsel == 2'b11) && w_strb_r[0]) begin
            done_s[i] = done_r[i] & ~w_data_r[0];
            err_s[i]  = err_r[i] & ~w_data_r[2];
         end else begin
            done_s[i] = done_r[i];
         end
         if (busy_r[i] && done[i]) begin
            result_s[i] = result_out[32*i +: 32];
            done_s[i]   = 1'b1;
            busy_s[i]   = 1'b0;
         end else if (busy_r[i] && (tmo_r[i] == TMO_LAST)) begin
            err_s[i]  = 1'b1;
            busy_s[i] = 1'b0;
         end else begin
            busy_s[i] = busy_r[i];
         end
         if (ctl_rst_r[i]) begin
            busy_s[i] = 1'b0;
            tmo_s[i]  = '0;
         end else begin
            start_s[i] = 1'b0;
         end
         // Start is gated by the rst bit written in the same CTRL word.
         if (ch_hit_s[i] && (wdec_s.rsel == 2'b10) && w_strb_r[0] && w_data_r[1] &&
             !w_data_r[0] && !busy_r[i]) begin
            busy_s[i]  = 1'b1;
            done_s[i]  = 1'b0;
            err_s[i]   = 1'b0;
            tmo_s[i]   = '0;
            start_s[i] = 1'b1;
         end else begin
            start_s[i] = 1'b0;
         end
      end
      irq_s = |((done_s | err_s) & irq_en_s);
   end

   // Read data mux from current (pre-commit) register state.
   always_comb begin
      rd_data_s = 32'd0;
      rd_resp_s = rdec_s.ok ? 2'b00 : 2'b10;
      for (int i = 0; i < NUM_CH; i++) begin
         case (rdec_s.rsel)
            2'b00:   ch_word_s[i] = theta_r[i];
            2'b01:   ch_word_s[i] = result_r[i];
            2'b10:   ch_word_s[i] = {29'd0, mode_r[i], 1'b0, ctl_rst_r[i]};
            2'b11:   ch_word_s[i] = {29'd0, err_r[i], busy_r[i], done_r[i]};
            default: ch_word_s[i] = 32'd0;
         endcase
         rd_data_s = (rdec_s.ok && !rdec_s.glob && (rdec_s.ch == 3'(i))) ? ch_word_s[i] : rd_data_s;
      end
      if (rdec_s.ok && rdec_s.glob) begin
         rd_data_s = 32'(irq_en_r);
      end else begin
         rd_data_s = rd_data_s;
      end
   end

   // Handshake holding registers, responses and channel state.
   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
         aw_addr_r <= 32'd0;
         w_data_r  <= 32'd0;
         w_strb_r  <= 4'd0;
         bvalid_r  <= 1'b0;
         bresp_r   <= 2'b00;
         rvalid_r  <= 1'b0;
         rresp_r   <= 2'b00;
         rdata_r   <= 32'd0;
         irq_en_r  <= '0;
         ctl_rst_r <= '0;
         mode_r    <= '0;
         done_r    <= '0;
         busy_r    <= '0;
         err_r     <= '0;
         start_r   <= '0;
         irq_r     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            theta_r[i]  <= 32'd0;
            result_r[i] <= 32'd0;
            tmo_r[i]    <= '0;
         end
      end else begin
         if (commit_s) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_ok_s ? 2'b00 : 2'b10;
         end else begin
            if (aw_hs_s) begin
               aw_held_r <= 1'b1;
               aw_addr_r <= awaddr;
            end
            if (w_hs_s) begin
               w_held_r <= 1'b1;
               w_data_r <= wdata;
               w_strb_r <= wstrb;
            end
            if (bready) begin
               bvalid_r <= 1'b0;
            end
         end
         if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
         end else if (rready) begin
            rvalid_r <= 1'b0;
         end
         irq_en_r  <= irq_en_s;
         ctl_rst_r <= ctl_rst_s;
         mode_r    <= mode_s;
         done_r    <= done_s;
         busy_r    <= busy_s;
         err_r     <= err_s;
         start_r   <= start_s;
         irq_r     <= irq_s;
         for (int i = 0; i < NUM_CH; i++) begin
            theta_r[i]  <= theta_s[i];
            result_r[i] <= result_s[i];
            tmo_r[i]    <= tmo_s[i];
         end
      end
   end

   // Flatten channel angles onto the packed output bus.
   always_comb begin
      theta_deg = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         theta_deg[32*i +: 32] = theta_r[i];
      end
   end

   assign awready = ~areset & ~aw_held_r;
   assign wready  = ~areset & ~w_held_r;
   assign arready = ~areset & ~rvalid_r;
   assign bvalid  = bvalid_r;
   assign bresp   = bresp_r;
   assign rvalid  = rvalid_r;
   assign rresp   = rresp_r;
   assign rdata   = rdata_r;
   assign mode    = mode_r;
   assign rst     = ctl_rst_r;
   assign start   = start_r;
   assign irq     = irq_r;

endmodule

// File: tb/tb_axi4_lite_cordic_mc_controller.sv
// Directed bench for the multi-channel CORDIC AXI4-Lite controller.
// Expected responses are queued when a transaction is issued and popped when the DUT answers.
module tb_axi4_lite_cordic_mc_controller;

   localparam logic [31:0] BASE = 32'hF000_0100;
   localparam logic [31:0] GLOB = 32'hF000_0140;

   logic         aclk = 1'b0;
   logic         areset;
   logic [31:0]  awaddr, wdata, araddr, rdata;
   logic [3:0]   wstrb;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready, irq;
   logic [1:0]   bresp, rresp;
   logic [127:0] theta_deg, result_out;
   logic [3:0]   mode, start, rst, done;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
   } rd_exp_t;

   rd_exp_t    rd_q [$];
   logic [1:0] wr_q [$];
   int         checks   = 0;
   int         failures = 0;
   int         start_cnt [4];
   int         lat;

   axi4_lite_cordic_mc_controller #(
      .NUM_CH(4), .BASE_ADDR(32'hF000_0100), .CH_STRIDE(16), .TIMEOUT_CYC(16)
   ) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .theta_deg(theta_deg), .result_out(result_out), .mode(mode),
      .start(start), .rst(rst), .done(done), .irq(irq)
   );

   always #5 aclk = ~aclk;

   // Count high cycles of each start line to measure pulse count/width.
   always @(posedge aclk) begin
      for (int i = 0; i < 4; i++) begin
         start_cnt[i] <= areset ? 0 : start_cnt[i] + int'(start[i]);
      end
   end

   function automatic logic [31:0] ra(input int ch, input int off);
      return BASE + 32'(ch * 16 + off);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic axi_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] exp_resp,
                         input int w_lead, input int pulse_ch, output int lat_o);
      logic aw_hs, w_hs, aw_done, w_done;
      int   cyc;
      wr_q.push_back(exp_resp);
      @(negedge aclk);
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      wvalid  = 1'b1;
      awvalid = (w_lead == 0);
      aw_done = 1'b0;
      w_done  = 1'b0;
      cyc     = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge aclk); #1;
         cyc++;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
         if (!aw_done && !awvalid && cyc >= w_lead) awvalid = 1'b1;
      end
      chk({tag, "_hs"}, {31'd0, aw_done & w_done}, 32'd1);
      if (pulse_ch >= 0) done[pulse_ch] = 1'b1;
      lat_o = 0;
      while (!bvalid && lat_o < 40) begin
         @(posedge aclk); #1;
         lat_o++;
         done = 4'd0;
      end
      chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
      chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, wr_q.pop_front()});
      @(posedge aclk); #1;
      done = 4'd0;
   endtask

   task automatic axi_rd(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic [1:0] exp_r);
      logic    hs;
      int      cyc;
      rd_exp_t e;
      e.d = exp_d;
      e.r = exp_r;
      rd_q.push_back(e);
      @(negedge aclk);
      araddr  = a;
      arvalid = 1'b1;
      hs      = 1'b0;
      cyc     = 0;
      while (!hs && cyc < 40) begin
         hs = arvalid && arready;
         @(posedge aclk); #1;
         cyc++;
      end
      arvalid = 1'b0;
      cyc = 0;
      while (!rvalid && cyc < 40) begin
         @(posedge aclk); #1;
         cyc++;
      end
      chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
      e = rd_q.pop_front();
      chk({tag, "_rdata"}, rdata, e.d);
      chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, e.r});
      @(posedge aclk); #1;
   endtask

   initial begin
      areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; araddr = 32'd0;
      bready = 1'b1; rready = 1'b1; done = 4'd0; result_out = 128'd0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_awready_low", {31'd0, awready}, 32'd0);
      chk("rst_arready_low", {31'd0, arready}, 32'd0);
      areset = 1'b0;
      #1;
      chk("rst_ready_high", {29'd0, awready, wready, arready}, 32'd7);
      chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
      chk("rst_outs", {26'd0, irq, start, rst[0]}, 32'd0);
      chk("rst_theta", 32'(theta_deg != 128'd0), 32'd0);

      // AW/W together: bvalid one edge after the handshake edge's successor
      axi_wr("w_theta2", ra(2, 0), 32'd45, 4'hF, 2'b00, 0, -1, lat);
      chk("w_latency", 32'(lat), 32'd1);
      chk("theta_deg2", theta_deg[95:64], 32'd45);
      axi_rd("r_theta2", ra(2, 0), 32'd45, 2'b00);

      axi_wr("w_lead", ra(0, 0), 32'hFFFF_FFE2, 4'hF, 2'b00, 3, -1, lat);
      axi_rd("r_theta0", ra(0, 0), 32'hFFFF_FFE2, 2'b00);

      // Channel 1 start, completion, interrupt and W1C
      axi_wr("w_ctrl1", ra(1, 8), 32'h6, 4'hF, 2'b00, 0, -1, lat);
      chk("start1_once", 32'(start_cnt[1]), 32'd1);
      chk("mode1", {28'd0, mode}, 32'h2);
      axi_rd("r_stat1_busy", ra(1, 12), 32'h2, 2'b00);
      axi_rd("r_ctrl1", ra(1, 8), 32'h4, 2'b00);
      @(negedge aclk);
      result_out[63:32] = 32'd1234;
      done[1] = 1'b1;
      @(negedge aclk);
      done = 4'd0;
      axi_rd("r_res1", ra(1, 4), 32'd1234, 2'b00);
      axi_rd("r_stat1_done", ra(1, 12), 32'h1, 2'b00);
      axi_wr("w_irqen", GLOB, 32'h2, 4'hF, 2'b00, 0, -1, lat);
      chk("irq_set", {31'd0, irq}, 32'd1);
      axi_wr("w_w1c1", ra(1, 12), 32'h1, 4'hF, 2'b00, 0, -1, lat);
      chk("irq_clr", {31'd0, irq}, 32'd0);
      axi_rd("r_stat1_clr", ra(1, 12), 32'h0, 2'b00);

      // Channel 3 timeout; second start while busy is ignored
      axi_wr("w_ctrl3a", ra(3, 8), 32'h2, 4'hF, 2'b00, 0, -1, lat);
      axi_wr("w_ctrl3b", ra(3, 8), 32'h2, 4'hF, 2'b00, 0, -1, lat);
      axi_rd("r_stat3_busy", ra(3, 12), 32'h2, 2'b00);
      repeat (20) @(posedge aclk);
      #1;
      axi_rd("r_stat3_err", ra(3, 12), 32'h4, 2'b00);
      chk("start3_once", 32'(start_cnt[3]), 32'd1);
      chk("irq_masked", {31'd0, irq}, 32'd0);
      axi_wr("w_irqen2", GLOB, 32'hA, 4'hF, 2'b00, 0, -1, lat);
      chk("irq_err", {31'd0, irq}, 32'd1);
      axi_rd("r_res3", ra(3, 4), 32'd0, 2'b00);

      // Error responses
      axi_wr("w_result", ra(0, 4), 32'hDEAD_BEEF, 4'hF, 2'b10, 0, -1, lat);
      axi_wr("w_far", BASE + 32'h1000, 32'h1, 4'hF, 2'b10, 0, -1, lat);
      axi_wr("w_unalign", BASE + 32'h2, 32'h1234, 4'hF, 2'b10, 0, -1, lat);
      axi_rd("r_theta0_keep", ra(0, 0), 32'hFFFF_FFE2, 2'b00);
      axi_rd("r_far", BASE + 32'h1000, 32'd0, 2'b10);
      axi_rd("r_res0_keep", ra(0, 4), 32'd0, 2'b00);

      // W1C of DONE colliding with the hardware set
      result_out[31:0] = 32'd777;
      axi_wr("w_ctrl0", ra(0, 8), 32'h2, 4'hF, 2'b00, 0, -1, lat);
      axi_wr("w_w1c0", ra(0, 12), 32'h1, 4'hF, 2'b00, 0, 0, lat);
      axi_rd("r_stat0_set", ra(0, 12), 32'h1, 2'b00);
      axi_rd("r_res0", ra(0, 4), 32'd777, 2'b00);

      // Reset with a write response outstanding
      bready = 1'b0;
      axi_wr("w_pending", ra(2, 0), 32'h55, 4'hF, 2'b00, 0, -1, lat);
      chk("bvalid_pending", {31'd0, bvalid}, 32'd1);
      areset = 1'b1;
      @(posedge aclk); #1;
      chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
      chk("mid_rst_theta", 32'(theta_deg != 128'd0), 32'd0);
      chk("mid_rst_irq", {31'd0, irq}, 32'd0);
      chk("mid_rst_awready", {31'd0, awready}, 32'd0);
      areset = 1'b0;
      bready = 1'b1;
      #1;
      chk("post_rst_awready", {31'd0, awready}, 32'd1);
      axi_rd("r_theta2_rst", ra(2, 0), 32'd0, 2'b00);
      axi_rd("r_irqen_rst", GLOB, 32'd0, 2'b00);
      axi_rd("r_stat3_rst", ra(3, 12), 32'd0, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi4_lite_cordic_mc_controller.md
Name: axi4_lite_cordic_mc_controller

Overview:
Parametrised multi-channel AXI4-Lite slave that fronts NUM_CH independent CORDIC cores through one relocatable register window. Each channel has its own register bank: angle, latched result, control, and sticky status. New over the single-channel controller: independent AW/W acceptance, concurrent read/write paths, result capture on done, W1C status, per-channel busy timeout, and a maskable interrupt. Sits between the SoC interconnect and a bank of CORDIC cores.

Parameters:
NUM_CH, 4, number of CORDIC channels (1..8)
BASE_ADDR, 32'hF0000100, byte base of register window (16-byte aligned)
CH_STRIDE, 16, byte stride between channel banks (power of 2, >=16)
TIMEOUT_CYC, 1024, busy cycles before a channel is declared timed out (>=2)

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
awaddr/awvalid/awready  in/in/out  32/1/1  AXI write address
wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI write data
bresp/bvalid/bready  out/out/in  2/1/1  AXI write response
araddr/arvalid/arready  in/in/out  32/1/1  AXI read address
rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI read data
theta_deg  out  32*NUM_CH  per-channel signed angle; ch i at [32i+31:32i]
result_out  in  32*NUM_CH  per-channel signed CORDIC result
mode  out  NUM_CH  per-channel mode
start  out  NUM_CH  per-channel one-cycle start pulse
rst  out  NUM_CH  per-channel core reset level
done  in  NUM_CH  per-channel completion pulse
irq  out  1  OR over channels of (DONE|ERR) & IRQ_EN[i]

Behaviour:
- Map, offset from BASE_ADDR + i*CH_STRIDE: +0x0 THETA (RW, byte strobes honoured); +0x4 RESULT (RO); +0x8 CTRL (RW; bit0 rst, bit1 start, bit2 mode; start is write-only and reads 0); +0xC STATUS (bit0 DONE, bit1 BUSY, bit2 ERR; bits 0 and 2 W1C, BUSY RO).
- Global register at BASE_ADDR + NUM_CH*CH_STRIDE: IRQ_EN[NUM_CH-1:0] (RW).
- Any other address, or a write to RESULT: resp 2'b10 (SLVERR), no state change, reads return 0. Unaligned address (awaddr[1:0]!=0): SLVERR.
- CTRL write updates only when wstrb[0]=1.
- Reset: awready=wready=arready=0 during reset, then 1 from the first cycle after reset. bvalid=rvalid=0, bresp=rresp=0, rdata=0, start=0, irq=0. All THETA/RESULT/CTRL/STATUS/IRQ_EN = 0, timeout counters = 0.
- Write path: AW and W are each captured in a one-entry holding register, in either order or together. awready = !aw_held; wready = !w_held.
- Write commit: occurs in the first cycle with aw_held & w_held & !bvalid. At that edge: register update, bvalid=1, holding registers cleared.
- Write latency: AW and W presented together in cycle 0 are handshaken at edge 0, committed in cycle 1, and bvalid is high from cycle 2. bvalid holds until bready.
- Start: a committed CTRL write with bit1=1 on a non-busy channel with rst=0 pulses start[i] for exactly one cycle, in the cycle after the commit. Same edge: BUSY=1, DONE=0, ERR=0, timeout counter cleared.
- Start while BUSY, or with rst=1: ignored; response is still OKAY.
- Completion: done[i] while BUSY captures result_out into RESULT, sets DONE=1, clears BUSY. done while not busy is ignored.
- Timeout: counter increments while BUSY. At count TIMEOUT_CYC-1, set ERR=1 and clear BUSY; RESULT is unchanged.
- rst[i]=1: clears BUSY and the timeout counter; DONE and ERR are kept.
- Collisions: a W1C on STATUS in the same cycle as a hardware set of DONE or ERR leaves the bit set (set wins).
- Read path: arready = !rvalid. At the AR handshake edge, rdata/rresp are registered from current state, and rvalid=1 from the next cycle until rready.
- Reads and writes proceed concurrently. A read handshaken on the same edge as a write commit returns the pre-commit value.
- areset mid-transaction: all pending handshakes are dropped and everything returns to reset values.

Test Plan:
- After reset, write THETA ch2=32'd45 (wstrb=4'hF), AW/W together -> bvalid in cycle 2 with OKAY; read back 45; theta_deg[95:64]=45.
- W presented 3 cycles before AW on ch0 THETA=32'hFFFF_FFE2 -> single commit, OKAY, readback 32'hFFFFFFE2.
- Ch1 CTRL=3'b110 -> start[1] one-cycle pulse, mode[1]=1, STATUS=3'b010. Drive done[1] with result_out ch1=32'd1234 -> RESULT=1234, STATUS=3'b001. With IRQ_EN=4'b0010, irq=1; W1C STATUS 1 -> irq=0.
- Ch3 start with TIMEOUT_CYC=16, no done -> ERR=1 and BUSY=0 after 16 busy cycles, irq if enabled. A second start during busy produces no extra start pulse.
- Write RESULT ch0, read BASE+0x1000, write with awaddr[1:0]=2 -> each SLVERR; registers unchanged; read returns 0.
- Same-cycle W1C of DONE on ch0 and done[0] pulse -> DONE remains 1. areset asserted while bvalid is pending -> bvalid=0 and registers zeroed on the next cycle.
